// File: rtl/sprite_mover.sv
// sprite_mover: moves a 5x5 sprite's top-left corner by one pixel per movement
// tick on a 160x120 playfield. The sprite waits in HOLD for HOLD_TICKS ticks
// after reset or respawn, then follows dir_in in RUN. Moves are clamped at the
// playfield edges. The previous position is kept for the erase logic.
module sprite_mover #(
  parameter int STEP_DIV   = 833333,
  parameter int HOLD_TICKS = 30,
  parameter int X_MAX      = 155,
  parameter int Y_MAX      = 115,
  parameter int X_INIT     = 76,
  parameter int Y_INIT     = 56
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] dir_in,
  input  logic       respawn,
  input  logic [7:0] reset_x,
  input  logic [6:0] reset_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [7:0] x_prev,
  output logic [6:0] y_prev,
  output logic       step,
  output logic       blocked,
  output logic       spawning
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  // One-hot codes. The other two encodings are illegal and fall back to HOLD.
  typedef enum logic [1:0] {
    S_HOLD = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [23:0]     r_div_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic [7:0]      r_x_prev;
  logic [6:0]      r_y_prev;
  logic            r_step;
  logic            r_blocked;

  logic            w_tick;
  logic            w_hold_done;
  logic            w_move;
  logic            w_wall;
  logic [7:0]      w_x_next;
  logic [6:0]      w_y_next;

  assign w_tick = enable && (r_div_cnt == 24'(STEP_DIV - 1));

  // State register. Respawn forces HOLD ahead of any tick on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (reset)        r_state <= S_HOLD;
    else if (respawn) r_state <= S_HOLD;
    else              r_state <= w_state_next;
  end

  // Next state, and the move or wall decision for this tick.
  always_comb begin
    // NOTE: every output gets a default before the case, so no latch is inferred.
    w_state_next = r_state;
    w_hold_done  = 1'b0;
    w_move       = 1'b0;
    w_wall       = 1'b0;
    w_x_next     = r_x;
    w_y_next     = r_y;
    case (r_state)
      S_HOLD: begin
        if (w_tick && (r_hold_cnt == HW'(HOLD_TICKS - 1))) begin
          w_state_next = S_RUN;
          w_hold_done  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_tick) begin
          case (dir_in)
            3'b000: if (r_x >= 8'(X_MAX)) w_wall = 1'b1;
                    else begin w_move = 1'b1; w_x_next = r_x + 8'd1; end
            3'b001: if (r_x == 8'd0) w_wall = 1'b1;
                    else begin w_move = 1'b1; w_x_next = r_x - 8'd1; end
            3'b010: if (r_y == 7'd0) w_wall = 1'b1;
                    else begin w_move = 1'b1; w_y_next = r_y - 7'd1; end
            3'b011: if (r_y >= 7'(Y_MAX)) w_wall = 1'b1;
                    else begin w_move = 1'b1; w_y_next = r_y + 7'd1; end
            default: ; // 1xx: no move, and blocked clears
          endcase
        end
      end
      default: w_state_next = S_HOLD;
    endcase
  end

  // Divider, hold counter, position and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_hold_cnt <= '0;
      r_x        <= 8'(X_INIT);
      r_y        <= 7'(Y_INIT);
      r_x_prev   <= 8'(X_INIT);
      r_y_prev   <= 7'(Y_INIT);
      r_step     <= 1'b0;
      r_blocked  <= 1'b0;
    end else if (respawn) begin
      r_div_cnt  <= '0;
      r_hold_cnt <= '0;
      r_x        <= reset_x;
      r_y        <= reset_y;
      r_x_prev   <= reset_x;
      r_y_prev   <= reset_y;
      r_step     <= 1'b0;
      r_blocked  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (enable) r_div_cnt <= w_tick ? 24'd0 : r_div_cnt + 24'd1;
      if (r_state == S_HOLD && w_tick)
        r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + HW'(1);
      if (r_state == S_RUN && w_tick) begin
        r_blocked <= w_wall;
        if (w_move) begin
          r_x_prev <= r_x;
          r_y_prev <= r_y;
          r_x      <= w_x_next;
          r_y      <= w_y_next;
          r_step   <= 1'b1;
        end
      end
    end
  end

  assign x_out    = r_x;
  assign y_out    = r_y;
  assign x_prev   = r_x_prev;
  assign y_prev   = r_y_prev;
  assign step     = r_step;
  assign blocked  = r_blocked;
  assign spawning = (r_state != S_RUN);

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover using STEP_DIV=4 and HOLD_TICKS=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] dir_in;
  logic       respawn;
  logic [7:0] reset_x;
  logic [6:0] reset_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [7:0] x_prev;
  logic [6:0] y_prev;
  logic       step;
  logic       blocked;
  logic       spawning;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sprite_mover #(
    .STEP_DIV(4), .HOLD_TICKS(2), .X_MAX(155), .Y_MAX(115),
    .X_INIT(10), .Y_INIT(20)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in),
    .respawn(respawn), .reset_x(reset_x), .reset_y(reset_y),
    .x_out(x_out), .y_out(y_out), .x_prev(x_prev), .y_prev(y_prev),
    .step(step), .blocked(blocked), .spawning(spawning)
  );

  always #5 clk = ~clk;

  // Each call advances n rising edges and ends on a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; dir_in = 3'b000;
    respawn = 1'b0; reset_x = '0; reset_y = '0;
    cyc(2);
    reset = 1'b0;
    chk_cnt++; if (x_out !== 8'd10) $display("FAIL reset_x got %0d want 10", x_out); else pass_cnt++;
    chk_cnt++; if (y_out !== 7'd20) $display("FAIL reset_y got %0d want 20", y_out); else pass_cnt++;
    chk_cnt++; if (x_prev !== 8'd10 || y_prev !== 7'd20)
      $display("FAIL reset_prev got %0d,%0d want 10,20", x_prev, y_prev); else pass_cnt++;
    chk_cnt++; if (spawning !== 1'b1 || step !== 1'b0 || blocked !== 1'b0)
      $display("FAIL reset_flags got sp=%b st=%b bl=%b want 1,0,0", spawning, step, blocked); else pass_cnt++;
    cyc(7);
    chk_cnt++; if (spawning !== 1'b1) $display("FAIL hold_7th got spawning=%b want 1", spawning); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (spawning !== 1'b0) $display("FAIL hold_8th got spawning=%b want 0", spawning); else pass_cnt++;
    chk_cnt++; if (x_out !== 8'd10 || y_out !== 7'd20 || step !== 1'b0)
      $display("FAIL hold_nomove got %0d,%0d step=%b want 10,20 step=0", x_out, y_out, step); else pass_cnt++;
  endtask

  task automatic test_run;
    cyc(3);
    chk_cnt++; if (x_out !== 8'd10) $display("FAIL run_early got x=%0d want 10", x_out); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (x_out !== 8'd11 || x_prev !== 8'd10 || step !== 1'b1)
      $display("FAIL run_px got x=%0d xp=%0d step=%b want 11,10,1", x_out, x_prev, step); else pass_cnt++;
    dir_in = 3'b011;
    cyc(1);
    chk_cnt++; if (step !== 1'b0) $display("FAIL run_step_pulse got step=%b want 0", step); else pass_cnt++;
    cyc(3);
    chk_cnt++; if (y_out !== 7'd21 || y_prev !== 7'd20 || x_out !== 8'd11 || x_prev !== 8'd11 || step !== 1'b1)
      $display("FAIL run_py got x=%0d y=%0d xp=%0d yp=%0d st=%b want 11,21,11,20,1",
               x_out, y_out, x_prev, y_prev, step); else pass_cnt++;
  endtask

  task automatic test_walls;
    respawn = 1'b1; reset_x = 8'd155; reset_y = 7'd0;
    cyc(1);
    respawn = 1'b0;
    chk_cnt++; if (x_out !== 8'd155 || y_out !== 7'd0 || spawning !== 1'b1)
      $display("FAIL wall_respawn got %0d,%0d sp=%b want 155,0,1", x_out, y_out, spawning); else pass_cnt++;
    dir_in = 3'b000;
    cyc(8);
    chk_cnt++; if (spawning !== 1'b0) $display("FAIL wall_run got spawning=%b want 0", spawning); else pass_cnt++;
    cyc(4);
    chk_cnt++; if (x_out !== 8'd155 || blocked !== 1'b1 || step !== 1'b0)
      $display("FAIL wall_xmax got x=%0d bl=%b st=%b want 155,1,0", x_out, blocked, step); else pass_cnt++;
    dir_in = 3'b010;
    cyc(4);
    chk_cnt++; if (y_out !== 7'd0 || blocked !== 1'b1 || y_prev !== 7'd0)
      $display("FAIL wall_y0 got y=%0d bl=%b yp=%0d want 0,1,0", y_out, blocked, y_prev); else pass_cnt++;
    dir_in = 3'b001;
    cyc(4);
    chk_cnt++; if (x_out !== 8'd154 || blocked !== 1'b0 || x_prev !== 8'd155 || step !== 1'b1)
      $display("FAIL wall_leave got x=%0d bl=%b xp=%0d st=%b want 154,0,155,1",
               x_out, blocked, x_prev, step); else pass_cnt++;
  endtask

  task automatic test_pause;
    dir_in = 3'b000;
    cyc(2);
    enable = 1'b0;
    cyc(10);
    chk_cnt++; if (x_out !== 8'd154 || step !== 1'b0)
      $display("FAIL pause_hold got x=%0d st=%b want 154,0", x_out, step); else pass_cnt++;
    enable = 1'b1;
    cyc(1);
    chk_cnt++; if (x_out !== 8'd154) $display("FAIL pause_resume1 got x=%0d want 154", x_out); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (x_out !== 8'd155 || step !== 1'b1)
      $display("FAIL pause_resume2 got x=%0d st=%b want 155,1", x_out, step); else pass_cnt++;
  endtask

  task automatic test_respawn_collision;
    dir_in = 3'b011;
    cyc(3);
    respawn = 1'b1; reset_x = 8'd40; reset_y = 7'd50;
    cyc(1);
    respawn = 1'b0;
    chk_cnt++; if (x_out !== 8'd40 || y_out !== 7'd50 || x_prev !== 8'd40 || y_prev !== 7'd50)
      $display("FAIL collide_pos got %0d,%0d prev %0d,%0d want 40,50 prev 40,50",
               x_out, y_out, x_prev, y_prev); else pass_cnt++;
    chk_cnt++; if (step !== 1'b0 || spawning !== 1'b1 || blocked !== 1'b0)
      $display("FAIL collide_flags got st=%b sp=%b bl=%b want 0,1,0", step, spawning, blocked); else pass_cnt++;
    cyc(4);
    chk_cnt++; if (y_out !== 7'd50 || spawning !== 1'b1)
      $display("FAIL collide_hold got y=%0d sp=%b want 50,1", y_out, spawning); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    respawn = 1'b1; reset_x = 8'd30; reset_y = 7'd30; dir_in = 3'b100;
    cyc(1);
    respawn = 1'b0;
    cyc(10);
    chk_cnt++; if (x_out !== 8'd30 || y_out !== 7'd30 || spawning !== 1'b0)
      $display("FAIL areset_pre got %0d,%0d sp=%b want 30,30,0", x_out, y_out, spawning); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++; if (x_out !== 8'd10 || y_out !== 7'd20 || spawning !== 1'b1)
      $display("FAIL areset_now got %0d,%0d sp=%b want 10,20,1", x_out, y_out, spawning); else pass_cnt++;
    chk_cnt++; if (x_prev !== 8'd10 || y_prev !== 7'd20)
      $display("FAIL areset_prev got %0d,%0d want 10,20", x_prev, y_prev); else pass_cnt++;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_walls();
    test_pause();
    test_respawn_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
